// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus widths, memory slave decode and copy FSM state encoding
package bus_pkg;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 64;

  // upper address byte that selects the memory slave
  localparam logic [7:0] MEM_SLAVE_SEL = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RD    = 3'd2,
    S_RWAIT = 3'd3,
    S_WR    = 3'd4,
    S_DONE  = 3'd5
  } copy_state_t;

endpackage

// File: rtl/copy_addr_ctr.sv
// rtl/copy_addr_ctr.sv - source/destination address and remaining-word counters for the copy engine
module copy_addr_ctr #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_in,
  input  logic [ADDR_W-1:0] dst_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic [ADDR_W-1:0] cur_src,
  output logic [ADDR_W-1:0] cur_dst,
  output logic [ADDR_W-1:0] next_src,
  output logic              zero
);

  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] rem_next;

  // addresses wrap naturally at the top of the address space
  assign next_src = cur_src + ADDR_W'(1);
  assign rem_next = remaining - LEN_W'(1);
  // zero flag describes the count after the pending step, so the FSM can leave WR directly
  assign zero     = (rem_next == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
    end else if (load) begin
      cur_src   <= src_in;
      cur_dst   <= dst_in;
      remaining <= len_in;
    end else if (step) begin
      cur_src   <= next_src;
      cur_dst   <= cur_dst + ADDR_W'(1);
      remaining <= rem_next;
    end
  end

endmodule

// File: rtl/bus_copy_master.sv
// rtl/bus_copy_master.sv - bus master copying a block of words from src to dst, one read/write pair per word
// Optional COPY_CHECKSUM_EN adds a 32-bit running sum of the low halves of captured words.
module bus_copy_master
  import bus_pkg::*;
#(
  parameter int DATA_W = BUS_DATA_W,
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              m_req,
  input  logic              m_grant,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
`ifdef COPY_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  input  logic [DATA_W-1:0] m_din
);

  copy_state_t       state;
  logic [1:0]        lat_cnt;
  logic              accept;
  logic              ctr_load;
  logic              ctr_step;
  logic              rd_last;
  logic              capture;
  logic              last_word;
  logic [ADDR_W-1:0] cur_src;
  logic [ADDR_W-1:0] cur_dst;
  logic [ADDR_W-1:0] next_src;

  assign accept   = (state == S_IDLE) && start;
  assign ctr_load = accept && (length != '0);
  assign ctr_step = (state == S_WR) && m_grant;
  assign rd_last  = (lat_cnt == 2'(RD_LAT - 1));
  assign capture  = (state == S_RWAIT) && m_grant && rd_last;

  copy_addr_ctr #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_ctr (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (ctr_load),
    .step     (ctr_step),
    .src_in   (src_addr),
    .dst_in   (dst_addr),
    .len_in   (length),
    .cur_src  (cur_src),
    .cur_dst  (cur_dst),
    .next_src (next_src),
    .zero     (last_word)
  );

  // m_dout doubles as the word buffer: it is loaded only when entering WR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      m_req   <= 1'b0;
      m_wr    <= 1'b0;
      m_addr  <= '0;
      m_dout  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (length != '0) begin
              state <= S_REQ;
              m_req <= 1'b1;
              m_wr  <= 1'b0;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (m_grant) begin
            state  <= S_RD;
            m_addr <= cur_src;
          end
        end
        S_RD: begin
          if (m_grant) begin
            state   <= S_RWAIT;
            lat_cnt <= '0;
          end
        end
        S_RWAIT: begin
          if (capture) begin
            state  <= S_WR;
            m_wr   <= 1'b1;
            m_addr <= cur_dst;
            m_dout <= m_din;
          end else if (m_grant) begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_WR: begin
          if (m_grant) begin
            m_wr <= 1'b0;
            if (last_word) begin
              state <= S_DONE;
              m_req <= 1'b0;
              done  <= 1'b1;
            end else begin
              state  <= S_RD;
              m_addr <= next_src;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef COPY_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (capture) begin
      checksum <= checksum + m_din[31:0];
    end
  end
`endif

endmodule
